// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared front-end/EX types for branch prediction and resolution
package core_pkg;

   localparam int XLEN       = 32;
   localparam int INST_BYTES = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      FLUSH = 1'b1
   } state_t;

   // Prediction made at fetch and carried down the pipeline with the instruction
   typedef struct packed {
      logic            taken;
      logic [XLEN-1:0] target;
   } br_pred_t;

endpackage

// File: rtl/branch_stat_ctr.sv
// rtl/branch_stat_ctr.sv - saturating statistics up-counter with enable
module branch_stat_ctr #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_en,
   output logic [CNT_W-1:0] o_cnt
);

   logic [CNT_W-1:0] r_cnt;

   // Sticks at all-ones so a long run never reports a misleadingly small count
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_en && (r_cnt != {CNT_W{1'b1}})) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - EX-stage branch check, redirect/flush and predictor training
module branch_resolve_unit
   import core_pkg::*;
#(
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ex_valid,
   input  logic             ex_is_br,
   input  logic [XLEN-1:0]  ex_pc,
   input  logic             ex_pred_taken,
   input  logic [XLEN-1:0]  ex_pred_target,
   input  logic             ex_taken,
   input  logic [XLEN-1:0]  ex_target,
   output logic             redirect,
   output logic [XLEN-1:0]  redirect_pc,
   output logic             flush,
   output logic             upd_valid,
   output logic [XLEN-1:0]  upd_pc,
   output logic             upd_taken,
   output logic [XLEN-1:0]  upd_target,
   output logic [CNT_W-1:0] cnt_branch,
   output logic [CNT_W-1:0] cnt_mispred
);

   br_pred_t        w_pred;
   state_t          r_state;
   state_t          w_next_state;
   logic [3:0]      r_flush_cnt;
   logic [3:0]      w_flush_cnt_next;
   logic            w_resolve;
   logic            w_mis;
   logic            w_redirect_now;
   logic [XLEN-1:0] w_correct_pc;

   logic            r_redirect;
   logic [XLEN-1:0] r_redirect_pc;
   logic            r_upd_valid;
   logic [XLEN-1:0] r_upd_pc;
   logic            r_upd_taken;
   logic [XLEN-1:0] r_upd_target;

   assign w_pred.taken  = ex_pred_taken;
   assign w_pred.target = ex_pred_target;

   // Anything presented while flushing is on the wrong path and is ignored
   assign w_resolve = ex_valid & ex_is_br & (r_state == IDLE);

   // Predicted target only matters when both sides agree the branch is taken
   assign w_mis = (w_pred.taken != ex_taken) |
                  (w_pred.taken & ex_taken & (w_pred.target != ex_target));

   assign w_correct_pc   = ex_taken ? ex_target : ex_pc + XLEN'(INST_BYTES);
   assign w_redirect_now = w_resolve & w_mis;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_flush_cnt <= '0;
      end else begin
         r_state     <= w_next_state;
         r_flush_cnt <= w_flush_cnt_next;
      end
   end

   always_comb begin
      w_next_state     = r_state;
      w_flush_cnt_next = r_flush_cnt;
      case (r_state)
         IDLE: begin
            if (w_redirect_now) begin
               w_next_state     = FLUSH;
               w_flush_cnt_next = 4'(FLUSH_CYCLES - 1);
            end
         end
         FLUSH: begin
            if (r_flush_cnt == 4'd0) begin
               w_next_state = IDLE;
            end else begin
               w_flush_cnt_next = r_flush_cnt - 4'd1;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_redirect    <= 1'b0;
         r_redirect_pc <= '0;
         r_upd_valid   <= 1'b0;
         r_upd_pc      <= '0;
         r_upd_taken   <= 1'b0;
         r_upd_target  <= '0;
      end else begin
         r_redirect  <= w_redirect_now;
         r_upd_valid <= w_resolve;
         if (w_redirect_now) begin
            r_redirect_pc <= w_correct_pc;
         end
         if (w_resolve) begin
            r_upd_pc    <= ex_pc;
            r_upd_taken <= ex_taken;
         end
         // Not-taken branches leave the BTB target alone
         if (w_resolve && ex_taken) begin
            r_upd_target <= ex_target;
         end
      end
   end

   branch_stat_ctr #(
      .CNT_W (CNT_W)
   ) u_cnt_branch (
      .clk   (clk),
      .rst   (rst),
      .i_en  (w_resolve),
      .o_cnt (cnt_branch)
   );

   branch_stat_ctr #(
      .CNT_W (CNT_W)
   ) u_cnt_mispred (
      .clk   (clk),
      .rst   (rst),
      .i_en  (w_redirect_now),
      .o_cnt (cnt_mispred)
   );

   assign redirect    = r_redirect;
   assign redirect_pc = r_redirect_pc;
   assign flush       = (r_state == FLUSH);
   assign upd_valid   = r_upd_valid;
   assign upd_pc      = r_upd_pc;
   assign upd_taken   = r_upd_taken;
   assign upd_target  = r_upd_target;

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- EX-stage counterpart to the fetch-side branch predictor.
- Compares the prediction carried down the pipeline with the actual branch outcome computed in EX.
- On a mismatch, issues a redirect PC and a timed front-end flush.
- Issues one registered training write per resolved branch for the BHT/BTB, and keeps branch and mispredict statistics.

Parameters:
- FLUSH_CYCLES, 2: cycles `flush` stays asserted after a mispredict (1..15).
- CNT_W, 32: width of the statistics counters.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- ex_valid  in  1  EX stage holds a valid instruction
- ex_is_br  in  1  the EX instruction is a conditional branch or jump
- ex_pc  in  32  PC of the EX instruction
- ex_pred_taken  in  1  taken/not-taken decision made at fetch
- ex_pred_target  in  32  target used at fetch; don't-care if predicted not-taken
- ex_taken  in  1  actual outcome from the ALU
- ex_target  in  32  actual target address
- redirect  out  1  one-cycle pulse: fetch must load redirect_pc
- redirect_pc  out  32  correct next PC
- flush  out  1  squash IF/ID contents while high
- upd_valid  out  1  one-cycle pulse: write the training entry below
- upd_pc  out  32  BHT/BTB index PC
- upd_taken  out  1  actual outcome for BHT training
- upd_target  out  32  target for BTB allocate/refresh
- cnt_branch  out  CNT_W  resolved branches
- cnt_mispred  out  CNT_W  mispredicted branches

Behaviour:
- Reset (rst=1 at a rising edge):
  - All outputs go to 0 on that edge; FSM goes to IDLE; the flush counter clears.
  - A reset during FLUSH aborts the flush immediately.
- Resolve condition: `ex_valid & ex_is_br & (state==IDLE)`. Instructions presented in FLUSH are wrong-path: no update, no count, no redirect.
- Mispredict (mis):
  - `ex_pred_taken != ex_taken`, or
  - `ex_pred_taken & ex_taken & (ex_pred_target != ex_target)`.
- Correct PC: `ex_taken ? ex_target : ex_pc + 32'd4`. The addition is modulo 2^32; `0xFFFFFFFC` wraps to `0x00000000`.
- Latency: every output is registered and reflects the EX input one cycle after the resolving edge.
- Training write, on each resolve:
  - Next cycle: `upd_valid=1` with `upd_pc=ex_pc`, `upd_taken=ex_taken`.
  - `upd_target = ex_target` if taken, otherwise the previous `upd_target` value.
  - `upd_valid` is 0 in every other cycle.
- Counters:
  - `cnt_branch` increments on each resolve; `cnt_mispred` increments on each resolve with mis.
  - Both saturate at all-ones; no wrap.
- FSM:
  - IDLE → FLUSH on resolve with mis.
    - Next cycle: `redirect=1`, `redirect_pc` = correct PC, `flush=1`, flush counter loaded with FLUSH_CYCLES-1.
  - FLUSH:
    - `flush` stays 1 and `redirect` is 0; the counter decrements each cycle.
    - On the cycle the counter is 0, `flush` is still 1, and the FSM returns to IDLE.
  - Total `flush` high time is exactly FLUSH_CYCLES cycles. `redirect_pc` holds its value until the next redirect.
- Back-to-back: a branch resolving in the first IDLE cycle after FLUSH is processed normally. A new mispredict there restarts the sequence.
- Non-branch or `ex_valid=0`: no output activity and no state change.
- X-safety: `ex_pred_target` is ignored when `ex_pred_taken=0`.

Decomposition:
- Shared package (`core_pkg`), which the fetch-side predictor also uses:
  - XLEN=32 and INST_BYTES=4 constants.
  - The 1-bit state enum {IDLE, FLUSH}.
  - A typedef `br_pred_t` {taken, target[31:0]} for the prediction carried down the pipeline.
- One natural sub-module, `branch_stat_ctr`: a saturating CNT_W up-counter with an enable, instantiated twice.
- The comparator and FSM stay in the top module.

Test Plan:
- Correct not-taken:
  - Stimulus: `ex_pc=0x100`, `pred_taken=0`, `taken=0`.
  - Response: next cycle `upd_valid=1`, `upd_pc=0x100`, `upd_taken=0`; `redirect=0`, `flush=0`; `cnt_branch=1`, `cnt_mispred=0`.
- Direction mispredict:
  - Stimulus: `ex_pc=0x200`, `pred_taken=0`, `taken=1`, `target=0x80`.
  - Response: next cycle `redirect=1`, `redirect_pc=0x80`; `flush` high exactly 2 cycles; `upd_target=0x80`; `cnt_mispred=1`.
- Target mispredict:
  - Stimulus: `pred_taken=1`, `pred_target=0x40`, `taken=1`, `target=0x44`.
  - Response: `redirect_pc=0x44`; `flush` for 2 cycles.
  - Second case, `pred_taken=1`, `taken=0` at `ex_pc=0xFFFFFFFC`: `redirect_pc=0x00000000`.
- Wrong-path suppression:
  - Stimulus: during both flush cycles, drive valid mispredicting branches.
  - Response: no `upd_valid`, no `redirect`; counters unchanged. A mispredicting branch on the first cycle after flush triggers a new redirect.
- Reset mid-flush:
  - Stimulus: assert `rst` on the 2nd flush cycle.
  - Response: next cycle `flush=0`, counters=0, state IDLE; a following correct branch gives `upd_valid=1` with no flush.
- Saturation:
  - Stimulus: with CNT_W=4, resolve 20 mispredicting branches separated by flush windows.
  - Response: `cnt_branch=15`, `cnt_mispred=15`.
